// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide unit.
// One operation in flight. The latency is fixed at 33 edges from the accepted
// start edge to the result_valid cycle.
//
// Handshake: start is sampled only while the unit is IDLE. It is ignored in
// every other state and is never queued. busy is high in every state except
// IDLE. result_valid is a one-cycle pulse in DONE. result is written only on
// the FIX->DONE edge and holds until the next operation completes.
module muldiv_unit #(
    parameter int XLEN  = 32,
    parameter int STEPS = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] rs1_val,
    input  logic [XLEN-1:0] rs2_val,
    output logic            busy,
    output logic            result_valid,
    output logic [XLEN-1:0] result
);

    localparam int CNT_W = $clog2(STEPS);

    localparam logic [2:0] OP_MUL    = 3'b000;
    localparam logic [2:0] OP_MULH   = 3'b001;
    localparam logic [2:0] OP_MULHSU = 3'b010;
    localparam logic [2:0] OP_MULHU  = 3'b011;
    localparam logic [2:0] OP_DIV    = 3'b100;
    localparam logic [2:0] OP_DIVU   = 3'b101;
    localparam logic [2:0] OP_REM    = 3'b110;
    localparam logic [2:0] OP_REMU   = 3'b111;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    // The state register is visible to bound checkers through this name.
    state_t state, state_nxt;

    logic [2:0]        op_q;
    logic [XLEN-1:0]   opnd_q;     // multiplicand (mul) or divisor (div), absolute value
    logic [2*XLEN-1:0] acc_q;      // mul: {partial product, multiplier}; div: {remainder, quotient}
    logic [CNT_W-1:0]  cnt_q;
    logic              a_neg_q;
    logic              b_neg_q;
    logic              b_zero_q;
    logic [XLEN-1:0]   a_raw_q;
    logic [XLEN-1:0]   result_q;

    // Operand conditioning at the start edge.
    logic            sign_a, sign_b, a_neg, b_neg;
    logic [XLEN-1:0] a_abs, b_abs;

    // Per-step datapath.
    logic [XLEN:0]     mul_sum;
    logic [2*XLEN-1:0] mul_next;
    logic [XLEN:0]     div_shift;
    logic [XLEN:0]     div_diff;
    logic [2*XLEN-1:0] div_next;

    // Sign fix-up.
    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   quo_fix, rem_fix;
    logic [XLEN-1:0]   fix_result;

    // Operand signedness and absolute values from funct3.
    always_comb begin
        sign_a = (op == OP_MUL) || (op == OP_MULH) || (op == OP_MULHSU) ||
                 (op == OP_DIV) || (op == OP_REM);
        sign_b = (op == OP_MUL) || (op == OP_MULH) ||
                 (op == OP_DIV) || (op == OP_REM);
        a_neg  = sign_a & rs1_val[XLEN-1];
        b_neg  = sign_b & rs2_val[XLEN-1];
        a_abs  = a_neg ? (~rs1_val + 1'b1) : rs1_val;
        b_abs  = b_neg ? (~rs2_val + 1'b1) : rs2_val;
    end

    // One shift-add step (multiply) and one restoring shift-subtract step (divide).
    always_comb begin
        mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
        mul_next  = {mul_sum, acc_q[XLEN-1:1]};
        div_shift = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
        div_diff  = div_shift - {1'b0, opnd_q};
        // A borrow in the top bit means the trial subtraction failed, so restore.
        if (div_diff[XLEN]) begin
            div_next = {div_shift[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
        end else begin
            div_next = {div_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
        end
    end

    // Sign correction and result selection. Signed overflow (MIN / -1) needs no
    // special path: |MIN| / 1 gives quotient MIN with remainder 0, and negating
    // MIN leaves MIN.
    always_comb begin
        prod_fix = (a_neg_q ^ b_neg_q) ? (~acc_q + 1'b1) : acc_q;
        quo_fix  = (a_neg_q ^ b_neg_q) ? (~acc_q[XLEN-1:0] + 1'b1) : acc_q[XLEN-1:0];
        rem_fix  = a_neg_q ? (~acc_q[2*XLEN-1:XLEN] + 1'b1) : acc_q[2*XLEN-1:XLEN];
        fix_result = '0;
        case (op_q)
            OP_MUL:                       fix_result = prod_fix[XLEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: fix_result = prod_fix[2*XLEN-1:XLEN];
            OP_DIV, OP_DIVU:              fix_result = b_zero_q ? '1 : quo_fix;
            OP_REM, OP_REMU:              fix_result = b_zero_q ? a_raw_q : rem_fix;
            default:                      fix_result = '0;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (start) state_nxt = S_CALC;
            S_CALC: if (cnt_q == CNT_W'(STEPS - 1)) state_nxt = S_FIX;
            S_FIX:  state_nxt = S_DONE;
            S_DONE: state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Datapath registers: operand latch, iteration and result capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q     <= '0;
            opnd_q   <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            a_neg_q  <= 1'b0;
            b_neg_q  <= 1'b0;
            b_zero_q <= 1'b0;
            a_raw_q  <= '0;
            result_q <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        op_q     <= op;
                        a_neg_q  <= a_neg;
                        b_neg_q  <= b_neg;
                        b_zero_q <= (rs2_val == '0);
                        a_raw_q  <= rs1_val;
                        cnt_q    <= '0;
                        if (op[2]) begin
                            opnd_q <= b_abs;
                            acc_q  <= {{XLEN{1'b0}}, a_abs};
                        end else begin
                            opnd_q <= a_abs;
                            acc_q  <= {{XLEN{1'b0}}, b_abs};
                        end
                    end
                end
                S_CALC: begin
                    acc_q <= op_q[2] ? div_next : mul_next;
                    cnt_q <= cnt_q + 1'b1;
                end
                S_FIX: begin
                    result_q <= fix_result;
                end
                default: ;
            endcase
        end
    end

    assign busy         = (state != S_IDLE);
    assign result_valid = (state == S_DONE);
    assign result       = result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: table vectors, randomized ops against a plain-arithmetic
// model, plus hand-written protocol and abort sequences.
module tb_muldiv_unit;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [2:0]  op;
  logic [31:0] rs1_val;
  logic [31:0] rs2_val;
  logic        busy;
  logic        result_valid;
  logic [31:0] result;

  int pass_cnt  = 0;
  int total_cnt = 0;
  logic [31:0] exp_q[$];

  typedef struct {
    logic [2:0]  f;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[14];

  muldiv_unit #(.XLEN(32), .STEPS(32)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .op           (op),
    .rs1_val      (rs1_val),
    .rs2_val      (rs2_val),
    .busy         (busy),
    .result_valid (result_valid),
    .result       (result)
  );

  // Clock and watchdog.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, total=%0d", total_cnt);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  // Reference model straight from the RV32M definitions.
  function automatic logic [31:0] ref_model(input logic [2:0] f, input logic [31:0] a,
                                            input logic [31:0] b);
    longint      sa, sb, ua, ub;
    logic [63:0] p;
    int          ia, ib;
    sa = $signed(a);
    sb = $signed(b);
    ua = longint'({32'b0, a});
    ub = longint'({32'b0, b});
    ia = a;
    ib = b;
    case (f)
      3'd0: begin p = sa * sb; return p[31:0];  end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        return ia / ib;
      end
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
        return ia % ib;
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  // Issue one op, then check latency, result, single pulse and return to idle.
  task automatic run_op(input string name, input logic [2:0] f, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp);
    int          n;
    logic [31:0] want;
    @(negedge clk);
    start = 1'b1; op = f; rs1_val = a; rs2_val = b;
    exp_q.push_back(exp);
    @(posedge clk); #1;
    start = 1'b0;
    // Operands only matter at the start edge.
    op = 3'($urandom); rs1_val = $urandom; rs2_val = $urandom;
    check({name, " busy_after_start"}, {31'b0, busy}, 32'd1);
    n = 0;
    for (int c = 1; c <= 40 && n == 0; c++) begin
      @(posedge clk); #1;
      if (result_valid) n = c;
    end
    check({name, " latency"}, 32'(n), 32'd33);
    want = exp_q.pop_front();
    check({name, " result"}, result, want);
    @(posedge clk); #1;
    check({name, " idle_after"}, {30'b0, busy, result_valid}, 32'd0);
    check({name, " result_held"}, result, want);
  endtask

  initial begin
    int          pulses;
    int          vcyc;
    logic [31:0] a, b, e;
    logic [2:0]  f;
    logic [31:0] corners[6];

    vecs[0]  = '{3'd0, 32'd6,          32'd7,          32'h0000_002A};
    vecs[1]  = '{3'd1, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'h0000_0000};
    vecs[2]  = '{3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'hFFFF_FFFE};
    vecs[3]  = '{3'd2, 32'hFFFF_FFFF,  32'h0000_0002,  32'hFFFF_FFFF};
    vecs[4]  = '{3'd0, 32'h8000_0000,  32'h0000_0002,  32'h0000_0000};
    vecs[5]  = '{3'd4, 32'hFFFF_FFF9,  32'h0000_0002,  32'hFFFF_FFFD};
    vecs[6]  = '{3'd6, 32'hFFFF_FFF9,  32'h0000_0002,  32'hFFFF_FFFF};
    vecs[7]  = '{3'd5, 32'hFFFF_FFF9,  32'h0000_0002,  32'h7FFF_FFFC};
    vecs[8]  = '{3'd7, 32'hFFFF_FFF9,  32'h0000_0002,  32'h0000_0001};
    vecs[9]  = '{3'd4, 32'd5,          32'd0,          32'hFFFF_FFFF};
    vecs[10] = '{3'd6, 32'd5,          32'd0,          32'h0000_0005};
    vecs[11] = '{3'd4, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000};
    vecs[12] = '{3'd6, 32'h8000_0000,  32'hFFFF_FFFF,  32'h0000_0000};
    vecs[13] = '{3'd6, 32'hFFFF_FFF9,  32'd0,          32'hFFFF_FFF9};

    corners[0] = 32'h0000_0000; corners[1] = 32'hFFFF_FFFF; corners[2] = 32'h8000_0000;
    corners[3] = 32'h7FFF_FFFF; corners[4] = 32'h0000_0001; corners[5] = 32'h0000_0002;

    // Reset with start held high.
    rst_n = 1'b0; start = 1'b1; op = 3'd0; rs1_val = 32'd6; rs2_val = 32'd7;
    repeat (3) @(posedge clk);
    #1;
    check("reset busy", {31'b0, busy}, 32'd0);
    check("reset result_valid", {31'b0, result_valid}, 32'd0);
    check("reset result", result, 32'd0);
    @(negedge clk);
    start = 1'b0; rst_n = 1'b1;

    // Directed vectors (back to back: each start lands the cycle after DONE).
    for (int i = 0; i < 14; i++)
      run_op($sformatf("vec%0d", i), vecs[i].f, vecs[i].a, vecs[i].b, vecs[i].exp);

    // Protocol: starts at cycles 5, 33 and 34 after an accepted start are ignored.
    @(negedge clk);
    start = 1'b1; op = 3'd5; rs1_val = 32'd1000; rs2_val = 32'd9;
    @(posedge clk);
    pulses = 0; vcyc = 0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      start = (c == 5 || c == 33 || c == 34);
      op = 3'($urandom); rs1_val = $urandom; rs2_val = $urandom;
      @(posedge clk); #1;
      if (result_valid) begin
        pulses++;
        if (vcyc == 0) vcyc = c;
      end
    end
    start = 1'b0;
    check("proto pulse_count", 32'(pulses), 32'd1);
    check("proto latency", 32'(vcyc), 32'd33);
    check("proto result", result, 32'd111);
    check("proto idle_after", {31'b0, busy}, 32'd0);

    // Abort: reset at cycle 15 of a DIV.
    @(negedge clk);
    start = 1'b1; op = 3'd4; rs1_val = 32'h1234_5678; rs2_val = 32'h0000_1234;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (15) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("abort busy", {31'b0, busy}, 32'd0);
    check("abort result_valid", {31'b0, result_valid}, 32'd0);
    check("abort result", result, 32'd0);
    pulses = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (result_valid || busy) pulses++;
    end
    check("abort quiet", 32'(pulses), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op("post_abort divu", 3'd5, 32'd100, 32'd7, 32'd14);
    run_op("post_abort remu", 3'd7, 32'd100, 32'd7, 32'd2);

    // Randomized ops against the reference model, biased toward corner operands.
    for (int i = 0; i < 48; i++) begin
      f = 3'($urandom_range(0, 7));
      a = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 5)] : $urandom;
      b = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 5)] : $urandom;
      if (f[2] && $urandom_range(0, 2) == 0) b = 32'($urandom_range(1, 300));
      e = ref_model(f, a, b);
      run_op($sformatf("rand%0d op%0d a=%08h b=%08h", i, f, a, b), f, a, b, e);
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
Iterative RV32M multiply/divide unit for the single-cycle core. It sits directly upstream of the writeback-select 2:1 mux and drives that mux's second data input. The core holds the PC while busy=1 and selects this unit's result on the cycle result_valid=1. Fixed latency, one operation in flight, no pipelining.

Parameters:
XLEN, 32, operand/result width (only 32 supported)
STEPS, 32, iteration count (must equal XLEN)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  request pulse; accepted only in IDLE
op  input  3  funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
rs1_val  input  32  operand A (dividend / multiplicand)
rs2_val  input  32  operand B (divisor / multiplier)
busy  output  1  high in any state other than IDLE
result_valid  output  1  one-cycle pulse, result valid
result  output  32  result; holds last value until next DONE

Behaviour:
- Reset (rst_n=0, asynchronous): state=IDLE, counter=0, busy=0, result_valid=0, result=0, all internal accumulators 0. Reset asserted mid-operation aborts it with no result pulse.
- States: IDLE, CALC, FIX, DONE.
- IDLE: if start=1 at edge E0, latch op, take absolute values of the operands per signedness, latch the sign flags, clear the accumulator and counter, and go to CALC. Otherwise stay.
- Signedness: MUL/MULH/DIV/REM treat both operands as signed. MULHSU treats A as signed and B as unsigned. MULHU/DIVU/REMU treat both as unsigned.
- CALC: one step per edge, 32 steps on edges E1..E32, counter 0..31. At counter==31, go to FIX.
  - Multiply: shift-add on a 64-bit unsigned product.
  - Divide: restoring shift-subtract, 32-bit quotient and 32-bit remainder.
- FIX (edge E33): apply sign correction and select the output, then go to DONE.
  - Product is negated if the operand signs differ (signed cases only).
  - MUL returns product[31:0]. MULH/MULHSU/MULHU return product[63:32].
  - Quotient is negated if the signs differ. Remainder takes the sign of the dividend.
- DONE: result_valid=1 for exactly this one cycle, busy=1. Next edge returns to IDLE.
- Latency: the start edge is E0 and result_valid is high between E33 and E34. Latency is fixed for all ops and values, including the special cases below.
- busy rises in the cycle after E0 and falls after E34. The core stalls while busy.
- Special cases (computed in FIX, still at fixed latency):
  - Divisor 0: DIV/DIVU give 0xFFFFFFFF. REM/REMU give rs1_val.
  - Signed overflow (rs1=0x80000000, rs2=0xFFFFFFFF): DIV gives 0x80000000, REM gives 0.
- start while not IDLE (including the DONE cycle): ignored, no queuing, latched operands unaffected.
- Operand inputs need only be stable at E0. Later changes have no effect.
- result changes only on the FIX→DONE transition and is stable between operations.

Test Plan:
- Reset: rst_n=0 with start=1 → busy=0, result_valid=0, result=0. Release rst_n, then start MUL 6×7 → result_valid exactly 33 cycles after the start edge, result=0x0000002A, single-cycle pulse.
- Signed high multiply: MULH 0xFFFFFFFF×0xFFFFFFFF → 0x00000000. MULHU same operands → 0xFFFFFFFE. MULHSU 0xFFFFFFFF×0x00000002 → 0xFFFFFFFF. MUL 0x80000000×2 → 0x00000000.
- Signed divide: DIV −7/2 (0xFFFFFFF9/0x2) → 0xFFFFFFFD, REM → 0xFFFFFFFF. DIVU 0xFFFFFFF9/2 → 0x7FFFFFFC, REMU → 1.
- Corners: DIV 5/0 → 0xFFFFFFFF and REM 5/0 → 5. DIV 0x80000000/0xFFFFFFFF → 0x80000000 and REM → 0. All at the same 33-cycle latency.
- Protocol: start pulses at cycles 5 and 33 after an accepted start are ignored (no second pulse, result unchanged). A start in the cycle after DONE is accepted.
- Abort: assert rst_n=0 at cycle 15 of a DIV → immediate busy=0, no result_valid. A fresh DIVU 100/7 after release gives 14 and REMU gives 2.
